// File: rtl/dense_layer_if.sv
// Read-request bus between the dense layer and its external RAM reader.
// One request outstanding at a time; the address is held until the data returns.
`timescale 1ns/1ps
interface dense_layer_if #(
    parameter int unsigned ADDR_WIDTH = 27
) ();
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_address;
    logic                  rd_valid;
    logic [15:0]           rd_data;

    modport master (output rd_req, rd_address, input rd_valid, rd_data);
    modport slave  (input rd_req, rd_address, output rd_valid, rd_data);
endinterface

// File: rtl/dense_layer.sv
// Fully connected layer: fetches bias and weights word by word from an external RAM
// reader, accumulates against a local Q8.8 input vector and emits one output per neuron.
`timescale 1ns/1ps
module dense_layer #(
    parameter int unsigned           IN_LEN      = 16,
    parameter int unsigned           OUT_LEN     = 32,
    parameter int unsigned           ADDR_WIDTH  = 27,
    parameter int unsigned           FRAC_BITS   = 8,
    parameter logic [ADDR_WIDTH-1:0] WEIGHT_BASE = 27'h000200,
    parameter logic [ADDR_WIDTH-1:0] BIAS_BASE   = 27'h000600,
    parameter bit                    RELU        = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_wr_en,
    input  logic [3:0]  in_wr_idx,
    input  logic [15:0] in_wr_data,
    input  logic        start,
    dense_layer_if.master rd_bus,
    output logic        busy,
    output logic        out_valid,
    output logic [4:0]  out_idx,
    output logic [15:0] out_data,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE, REQ_BIAS, WAIT_BIAS, REQ_W, WAIT_W, EMIT, FINISH
    } state_t;

    state_t                  r_state, w_next;
    logic [15:0]             r_x [IN_LEN];
    logic signed [39:0]      r_acc;
    logic [3:0]              r_i;
    logic [4:0]              r_j;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [4:0]              r_out_idx;
    logic [15:0]             r_out_data;

    logic                    w_last_i, w_last_j;
    logic signed [31:0]      w_prod;
    logic signed [39:0]      w_prod_ext, w_bias_ext, w_shift;
    logic [15:0]             w_result;

    assign w_last_i   = (r_i == 4'(IN_LEN - 1));
    assign w_last_j   = (r_j == 5'(OUT_LEN - 1));
    assign w_prod     = $signed(rd_bus.rd_data) * $signed(r_x[r_i]);
    assign w_prod_ext = 40'(w_prod);
    assign w_bias_ext = 40'($signed(rd_bus.rd_data)) <<< FRAC_BITS;
    assign w_shift    = r_acc >>> FRAC_BITS;

    always_comb begin
        w_result = w_shift[15:0];
        if (w_shift > 40'sd32767)
            w_result = 16'h7FFF;
        else if (w_shift < -40'sd32768)
            w_result = 16'h8000;
        if (RELU && w_result[15])
            w_result = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        rd_bus.rd_req = 1'b0;
        out_valid     = 1'b0;
        done          = 1'b0;
        busy          = (r_state != IDLE);
        case (r_state)
            IDLE:      if (start) w_next = REQ_BIAS;
            REQ_BIAS: begin
                rd_bus.rd_req = 1'b1;
                w_next        = WAIT_BIAS;
            end
            WAIT_BIAS: if (rd_bus.rd_valid) w_next = REQ_W;
            REQ_W: begin
                rd_bus.rd_req = 1'b1;
                w_next        = WAIT_W;
            end
            WAIT_W:    if (rd_bus.rd_valid) w_next = w_last_i ? EMIT : REQ_W;
            EMIT: begin
                out_valid = 1'b1;
                w_next    = w_last_j ? FINISH : REQ_BIAS;
            end
            FINISH: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default:   w_next = IDLE;
        endcase
    end

    // Address is registered one state ahead; weights of a row are contiguous,
    // so it simply increments after each weight instead of recomputing j*IN_LEN+i.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc      <= '0;
            r_i        <= '0;
            r_j        <= '0;
            r_addr     <= '0;
            r_out_idx  <= '0;
            r_out_data <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_j    <= '0;
                    r_addr <= BIAS_BASE;
                end
                WAIT_BIAS: if (rd_bus.rd_valid) begin
                    r_acc  <= w_bias_ext;
                    r_i    <= '0;
                    r_addr <= WEIGHT_BASE + ADDR_WIDTH'(r_j) * ADDR_WIDTH'(IN_LEN);
                end
                WAIT_W: if (rd_bus.rd_valid) begin
                    r_acc <= r_acc + w_prod_ext;
                    if (!w_last_i) begin
                        r_i    <= r_i + 4'd1;
                        r_addr <= r_addr + ADDR_WIDTH'(1);
                    end
                end
                EMIT: begin
                    r_out_idx  <= r_j;
                    r_out_data <= w_result;
                    if (!w_last_j) begin
                        r_j    <= r_j + 5'd1;
                        r_addr <= BIAS_BASE + ADDR_WIDTH'(r_j) + ADDR_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < IN_LEN; k++)
                r_x[k] <= '0;
        end else if (in_wr_en && (r_state == IDLE) && (32'(in_wr_idx) < IN_LEN)) begin
            r_x[in_wr_idx] <= in_wr_data;
        end
    end

    // The result is visible during EMIT itself and then held from the registers.
    assign out_data          = (r_state == EMIT) ? w_result : r_out_data;
    assign out_idx           = (r_state == EMIT) ? r_j : r_out_idx;
    assign rd_bus.rd_address = r_addr;

endmodule

// File: tb/tb_dense_layer.sv
// Bench for dense_layer: two instances (ReLU on/off) share stimulus and a RAM model;
// outputs are checked against an arithmetic model of the layer plus literal values.
`timescale 1ns/1ps
module tb_dense_layer;
    localparam int unsigned IN_LEN  = 16;
    localparam int unsigned OUT_LEN = 32;
    localparam int unsigned AW      = 27;
    localparam logic [26:0] WB      = 27'h000200;
    localparam logic [26:0] BB      = 27'h000600;

    logic        clk = 1'b0, reset = 1'b0, in_wr_en = 1'b0, start = 1'b0;
    logic [3:0]  in_wr_idx = '0;
    logic [15:0] in_wr_data = '0;
    logic        busy_r, ov_r, done_r, busy_l, ov_l, done_l;
    logic [4:0]  idx_r, idx_l;
    logic [15:0] od_r, od_l;

    dense_layer_if #(.ADDR_WIDTH(AW)) bus_r ();
    dense_layer_if #(.ADDR_WIDTH(AW)) bus_l ();

    dense_layer #(.RELU(1'b1)) u_relu (
        .clk(clk), .reset(reset), .in_wr_en(in_wr_en), .in_wr_idx(in_wr_idx),
        .in_wr_data(in_wr_data), .start(start), .rd_bus(bus_r), .busy(busy_r),
        .out_valid(ov_r), .out_idx(idx_r), .out_data(od_r), .done(done_r));

    dense_layer #(.RELU(1'b0)) u_lin (
        .clk(clk), .reset(reset), .in_wr_en(in_wr_en), .in_wr_idx(in_wr_idx),
        .in_wr_data(in_wr_data), .start(start), .rd_bus(bus_l), .busy(busy_l),
        .out_valid(ov_l), .out_idx(idx_l), .out_data(od_l), .done(done_l));

    initial forever #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] m_x [IN_LEN];
    logic [15:0] m_w [OUT_LEN][IN_LEN];
    logic [15:0] m_b [OUT_LEN];

    bit          pass_active = 0, done_seen = 0, spur = 0;
    int          exp_idx = 0, req_k = 0, lat_max = 1, pend = 0, start_cyc = 0, done_cyc = 0;
    logic [26:0] pend_addr = '0;
    logic [15:0] last_r = '0, last_l = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Layer output from the definition: bias*2^8 + sum w*x, floor-shift, clamp, optional ReLU.
    function automatic logic [15:0] model(input int j, input bit relu);
        longint acc = longint'($signed(m_b[j])) * 256;
        longint r;
        for (int i = 0; i < IN_LEN; i++)
            acc += longint'($signed(m_w[j][i])) * longint'($signed(m_x[i]));
        r = acc >>> 8;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        if (relu && r < 0) r = 0;
        return 16'(r);
    endfunction

    function automatic logic [15:0] mem_read(input logic [26:0] a);
        int off;
        if (a >= BB && a < BB + 27'(OUT_LEN)) return m_b[int'(a - BB)];
        if (a >= WB && a < WB + 27'(OUT_LEN * IN_LEN)) begin
            off = int'(a - WB);
            return m_w[off / IN_LEN][off % IN_LEN];
        end
        return 16'hDEAD;
    endfunction

    function automatic logic [26:0] exp_addr(input int k);
        int n = k / 17, m = k % 17;
        return (m == 0) ? BB + 27'(n) : WB + 27'(n * 16 + m - 1);
    endfunction

    // RAM reader: latency 1..lat_max, optional junk pulses while a request or EMIT is shown.
    initial begin
        bus_r.rd_valid = 1'b0; bus_r.rd_data = '0;
        bus_l.rd_valid = 1'b0; bus_l.rd_data = '0;
        forever begin
            @(posedge clk); #1;
            bus_r.rd_valid = 1'b0; bus_l.rd_valid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus_r.rd_valid = 1'b1; bus_l.rd_valid = 1'b1;
                    bus_r.rd_data = mem_read(pend_addr); bus_l.rd_data = bus_r.rd_data;
                    if (pass_active) chk("rd_addr_hold", bus_r.rd_address, pend_addr);
                end
            end else if (spur && (bus_r.rd_req || ov_r) && $urandom_range(0, 1) == 1) begin
                bus_r.rd_valid = 1'b1; bus_l.rd_valid = 1'b1;
                bus_r.rd_data = 16'($urandom); bus_l.rd_data = bus_r.rd_data;
            end
            if (bus_r.rd_req) begin
                pend = (lat_max <= 1) ? 1 : int'($urandom_range(1, lat_max));
                pend_addr = bus_r.rd_address;
                if (pass_active) begin
                    chk("rd_addr_seq", bus_r.rd_address, exp_addr(req_k));
                    chk("rd_req_lin", bus_l.rd_req, 1);
                    chk("rd_addr_lin", bus_l.rd_address, exp_addr(req_k));
                    req_k++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (ov_r) begin
            if (!pass_active || exp_idx >= OUT_LEN) chk("unexpected_out_valid", ov_r, 0);
            else begin
                chk("out_idx", idx_r, exp_idx);
                chk("out_data_relu", od_r, model(exp_idx, 1));
                chk("out_valid_lin", ov_l, 1);
                chk("out_idx_lin", idx_l, exp_idx);
                chk("out_data_lin", od_l, model(exp_idx, 0));
                last_r = od_r; last_l = od_l;
                exp_idx++;
            end
        end
        if (done_r) begin
            if (!pass_active) chk("unexpected_done", done_r, 0);
            else begin
                chk("done_count", exp_idx, OUT_LEN);
                chk("done_lin", done_l, 1);
                chk("busy_at_done", busy_r, 1);
                done_cyc = cyc;
                done_seen = 1;
            end
        end
    end

    task automatic write_x(input int i, input logic [15:0] v);
        @(negedge clk);
        in_wr_en = 1'b1; in_wr_idx = 4'(i); in_wr_data = v;
        m_x[i] = v;
        @(negedge clk);
        in_wr_en = 1'b0;
    endtask

    task automatic run_pass(input int lmax, input bit sp, input bit disturb, input bit chk_cyc);
        lat_max = lmax; spur = sp;
        exp_idx = 0; req_k = 0; done_seen = 0; pass_active = 1;
        @(negedge clk);
        start = 1'b1; start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        if (disturb) begin
            repeat (300) @(negedge clk);
            start = 1'b1; in_wr_en = 1'b1; in_wr_idx = 4'd3; in_wr_data = 16'h0500;
            @(negedge clk);
            start = 1'b0; in_wr_en = 1'b0;
        end
        for (int n = 0; n < 40000 && !done_seen; n++) @(negedge clk);
        chk("done_seen", done_seen, 1);
        if (chk_cyc) chk("pass_cycles", done_cyc - start_cyc, 1121);
        pass_active = 0; spur = 0;
        @(negedge clk);
        chk("busy_after", busy_r, 0);
        chk("busy_after_lin", busy_l, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy_r, 0);
        chk({tag, "_rd_req"}, bus_r.rd_req, 0);
        chk({tag, "_rd_address"}, bus_r.rd_address, 0);
        chk({tag, "_out_valid"}, ov_r, 0);
        chk({tag, "_out_idx"}, idx_r, 0);
        chk({tag, "_out_data"}, od_r, 0);
        chk({tag, "_done"}, done_r, 0);
        chk({tag, "_out_data_lin"}, od_l, 0);
    endtask

    initial begin
        for (int j = 0; j < OUT_LEN; j++) begin
            m_b[j] = '0;
            for (int i = 0; i < IN_LEN; i++) m_w[j][i] = '0;
        end
        for (int i = 0; i < IN_LEN; i++) m_x[i] = '0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b1;

        // All ones: each neuron sums sixteen 1.0 products; mid-pass start/write ignored.
        for (int i = 0; i < IN_LEN; i++) write_x(i, 16'h0100);
        for (int j = 0; j < OUT_LEN; j++) for (int i = 0; i < IN_LEN; i++) m_w[j][i] = 16'h0100;
        chk("model_pin_ones", model(0, 1), 16'h1000);
        run_pass(1, 0, 1, 1);
        chk("ones_last_relu", last_r, 16'h1000);
        chk("ones_last_lin", last_l, 16'h1000);
        chk("hold_out_data", od_r, 16'h1000);
        chk("hold_out_idx", idx_r, 31);

        // 2.0 * -1.0 + 0.5 = -1.5; other weights meet zero inputs.
        write_x(0, 16'h0200);
        for (int i = 1; i < IN_LEN; i++) write_x(i, 16'h0000);
        for (int j = 0; j < OUT_LEN; j++) begin
            m_b[j] = 16'h0080;
            m_w[j][0] = 16'hFF00;
            for (int i = 1; i < IN_LEN; i++) m_w[j][i] = 16'(j * 97 + i * 31);
        end
        chk("model_pin_neg_lin", model(7, 0), 16'hFE80);
        run_pass(1, 0, 0, 1);
        chk("neg_last_relu", last_r, 16'h0000);
        chk("neg_last_lin", last_l, 16'hFE80);

        // Positive overflow saturates.
        for (int i = 0; i < IN_LEN; i++) write_x(i, 16'h7FFF);
        for (int j = 0; j < OUT_LEN; j++) begin
            m_b[j] = 16'h7FFF;
            for (int i = 0; i < IN_LEN; i++) m_w[j][i] = 16'h7FFF;
        end
        run_pass(1, 0, 0, 1);
        chk("satpos_last_relu", last_r, 16'h7FFF);
        chk("satpos_last_lin", last_l, 16'h7FFF);

        // Negative overflow saturates.
        for (int j = 0; j < OUT_LEN; j++) for (int i = 0; i < IN_LEN; i++) m_w[j][i] = 16'h8000;
        chk("model_pin_satneg", model(3, 0), 16'h8000);
        run_pass(1, 0, 0, 1);
        chk("satneg_last_relu", last_r, 16'h0000);
        chk("satneg_last_lin", last_l, 16'h8000);

        // Mixed-sign values with random read latency and junk rd_valid pulses.
        for (int i = 0; i < IN_LEN; i++) write_x(i, 16'(((i * 97) % 1024) - 512));
        for (int j = 0; j < OUT_LEN; j++) begin
            m_b[j] = 16'((((j * 41) % 256) - 128) * 4);
            for (int i = 0; i < IN_LEN; i++) m_w[j][i] = 16'(((j * 131 + i * 57) % 512) - 256);
        end
        run_pass(20, 1, 0, 0);

        // Abort during neuron 5 with a slow read still in flight.
        lat_max = 20; exp_idx = 0; req_k = 0; done_seen = 0; pass_active = 1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int n = 0; n < 5000 && exp_idx < 5; n++) @(negedge clk);
        chk("abort_reached_n5", exp_idx, 5);
        repeat (10) @(negedge clk);
        #2;
        reset = 1'b0; pass_active = 0;
        #1;
        check_reset_outputs("abort");
        for (int i = 0; i < IN_LEN; i++) m_x[i] = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        chk("abort_idle_busy", busy_r, 0);
        chk("abort_no_done", done_seen, 0);

        // Start on the first edge after reset release; cleared inputs leave bias only.
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        lat_max = 1; exp_idx = 0; req_k = 0; done_seen = 0; pass_active = 1;
        reset = 1'b1; start = 1'b1; start_cyc = cyc;
        @(negedge clk); start = 1'b0;
        for (int n = 0; n < 40000 && !done_seen; n++) @(negedge clk);
        chk("post_abort_done", done_seen, 1);
        chk("post_abort_cycles", done_cyc - start_cyc, 1121);
        chk("post_abort_bias_only", last_l, 16'((((31 * 41) % 256) - 128) * 4));
        pass_active = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
